alu_issue_ctrl: RTL

- Issue/sequencing controller that drives the 16-bit datapath ALU and consumes its result.
- Accepts one decoded instruction per handshake and maps opcode/funct to the 3-bit ALU control code.
- Selects and registers operands, captures ALU result and Zero flag, resolves branches, and presents a writeback record downstream under valid/ready.
- Sits between register-read and register-writeback in the RISC core.

---
 rtl/alu_issue_ctrl.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue/sequencing controller for the 16-bit datapath ALU: decodes one instruction,
// drives the ALU from registers, captures its result and presents a writeback record.
module alu_issue_ctrl #(
  parameter int DATA_W = 16,
  parameter int IMM_W  = 6,
  parameter int PC_INC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [2:0]        in_funct,
  input  logic [2:0]        in_rd,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_rs_data,
  input  logic [DATA_W-1:0] in_rt_data,
  output logic [2:0]        alu_ctrl,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        out_rd,
  output logic [DATA_W-1:0] out_data,
  output logic              out_wb_en,
  output logic              out_branch_taken,
  output logic [DATA_W-1:0] out_branch_target,
  output logic              out_illegal,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_accept;
  logic   w_capture;

  logic [DATA_W-1:0] w_sext;
  logic [DATA_W-1:0] w_target;
  logic [2:0]        w_dec_ctrl;
  logic [DATA_W-1:0] w_dec_a;
  logic [DATA_W-1:0] w_dec_b;
  logic              w_dec_wb;
  logic              w_dec_illegal;
  logic              w_dec_beq;
  logic              w_dec_bne;

  logic [2:0]        r_alu_ctrl;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic [2:0]        r_out_rd;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_wb_en;
  logic              r_out_taken;
  logic [DATA_W-1:0] r_out_target;
  logic              r_out_illegal;
  logic              r_is_beq;
  logic              r_is_bne;

  assign w_sext   = {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};
  assign w_target = in_pc + DATA_W'(PC_INC) + w_sext;

  // Instruction decode into ALU control, operands and record attributes
  always_comb begin
    w_dec_ctrl    = 3'd0;
    w_dec_a       = in_rs_data;
    w_dec_b       = w_sext;
    w_dec_wb      = 1'b1;
    w_dec_illegal = 1'b0;
    w_dec_beq     = 1'b0;
    w_dec_bne     = 1'b0;
    case (in_op)
      4'b0000: begin w_dec_ctrl = in_funct; w_dec_b = in_rt_data; end
      4'b0001: w_dec_ctrl = 3'b000;
      4'b0010: w_dec_ctrl = 3'b001;
      4'b0011: w_dec_ctrl = 3'b101;
      4'b0100: w_dec_ctrl = 3'b110;
      4'b0101: w_dec_ctrl = 3'b111;
      4'b0110: begin
        w_dec_ctrl = 3'b001; w_dec_b = in_rt_data; w_dec_wb = 1'b0; w_dec_beq = 1'b1;
      end
      4'b0111: begin
        w_dec_ctrl = 3'b001; w_dec_b = in_rt_data; w_dec_wb = 1'b0; w_dec_bne = 1'b1;
      end
      default: begin
        w_dec_ctrl    = 3'b000;
        w_dec_a       = '0;
        w_dec_b       = '0;
        w_dec_wb      = 1'b0;
        w_dec_illegal = 1'b1;
      end
    endcase
    if (in_rd == 3'd0) begin
      w_dec_wb = 1'b0;
    end else begin
      w_dec_wb = w_dec_wb;
    end
  end

  // Next-state logic; flush aborts from any state, including a completing WB handshake
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    if (flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            w_state_nxt = S_EXEC;
            w_accept    = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_EXEC: begin
          w_state_nxt = S_WB;
          w_capture   = 1'b1;
        end
        S_WB: begin
          if (out_ready) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_WB;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State, operand and writeback-record registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_alu_ctrl    <= 3'd0;
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_out_rd      <= 3'd0;
      r_out_data    <= '0;
      r_out_wb_en   <= 1'b0;
      r_out_taken   <= 1'b0;
      r_out_target  <= '0;
      r_out_illegal <= 1'b0;
      r_is_beq      <= 1'b0;
      r_is_bne      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_alu_ctrl    <= w_dec_ctrl;
        r_alu_a       <= w_dec_a;
        r_alu_b       <= w_dec_b;
        r_out_rd      <= in_rd;
        r_out_wb_en   <= w_dec_wb;
        r_out_target  <= w_target;
        r_out_illegal <= w_dec_illegal;
        r_is_beq      <= w_dec_beq;
        r_is_bne      <= w_dec_bne;
      end
      if (w_capture) begin
        r_out_data  <= alu_result;
        r_out_taken <= (r_is_beq & alu_zero) | (r_is_bne & ~alu_zero);
      end
    end
  end

  assign in_ready          = (r_state == S_IDLE);
  assign busy              = (r_state != S_IDLE);
  assign out_valid         = (r_state == S_WB);
  assign alu_ctrl          = r_alu_ctrl;
  assign alu_a             = r_alu_a;
  assign alu_b             = r_alu_b;
  assign out_rd            = r_out_rd;
  assign out_data          = r_out_data;
  assign out_wb_en         = r_out_wb_en;
  assign out_branch_taken  = r_out_taken;
  assign out_branch_target = r_out_target;
  assign out_illegal       = r_out_illegal;

endmodule
